// File: rtl/matrix_accelerator.sv
`default_nettype none
// ============================================================================
// Module      : matrix_accelerator
// Description : Parallel FP16 (binary16) multiply array with a per-lane
//               staging bank, a two-cycle product pipeline and per-output
//               masked result registers.
//               Optional feature macro: FP_ROUND_NEAREST_EN
//                 defined   -> round-to-nearest-even on the 10-bit mantissa
//                 undefined -> truncate (round toward zero)
// Revision    : 1.0  initial release
// ============================================================================
module matrix_accelerator #(
  parameter int                 BITLEN    = 16,
  parameter int                 INPUTS    = 3,
  parameter int                 OUTPUTS   = 3,
  parameter int                 ADDRLEN   = 4,
  parameter logic [ADDRLEN-1:0] REST_ADDR = {ADDRLEN{1'b1}}
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic [INPUTS*BITLEN-1:0]   multiplier_input,
  input  logic [INPUTS*BITLEN-1:0]   multiplicand_input,
  input  logic [ADDRLEN-1:0]         AddressSelect,
  input  logic                       mStart,
  output logic [INPUTS-1:0]          mReady,
  input  logic                       direct,
  input  logic [OUTPUTS-1:0]         Add,
  output logic [OUTPUTS*32-1:0]      flatsumout
);

  // FP16 multiply. Subnormal inputs behave as signed zero and tiny results
  // flush to signed zero, so no denormal path is needed.
  function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
    logic              s;
    logic [4:0]        ea, eb;
    logic [9:0]        fa, fb;
    logic              nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic [21:0]       prod;
    logic [9:0]        mant;
    logic signed [7:0] e;
    logic [15:0]       res;
`ifdef FP_ROUND_NEAREST_EN
    logic              guard, sticky;
    logic [10:0]       mant_r;
`endif
    s      = a[15] ^ b[15];
    ea     = a[14:10];
    eb     = b[14:10];
    fa     = a[9:0];
    fb     = b[9:0];
    nan_a  = (ea == 5'h1F) && (fa != 10'd0);
    nan_b  = (eb == 5'h1F) && (fb != 10'd0);
    inf_a  = (ea == 5'h1F) && (fa == 10'd0);
    inf_b  = (eb == 5'h1F) && (fb == 10'd0);
    zero_a = (ea == 5'd0);
    zero_b = (eb == 5'd0);

    e    = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 8'sd15;
    prod = {11'd0, 1'b1, fa} * {11'd0, 1'b1, fb};
    // Significand product lies in [1,4): at most one bit of normalisation.
    if (prod[21]) begin
      mant = prod[20:11];
      e    = e + 8'sd1;
    end else begin
      mant = prod[19:10];
    end
`ifdef FP_ROUND_NEAREST_EN
    guard  = prod[21] ? prod[10] : prod[9];
    sticky = prod[21] ? (|prod[9:0]) : (|prod[8:0]);
    mant_r = {1'b0, mant} + {10'd0, guard & (sticky | mant[0])};
    mant   = mant_r[9:0];
    // Mantissa carry-out means 1.111..1 rounded up to 10.0: bump exponent.
    if (mant_r[10]) e = e + 8'sd1;
`endif

    if (nan_a || nan_b) begin
      res = 16'h7E00;
    end else if (inf_a || inf_b) begin
      res = (zero_a || zero_b) ? 16'h7E00 : {s, 5'h1F, 10'h000};
    end else if (zero_a || zero_b) begin
      res = {s, 15'h0000};
    end else if (e > 8'sd30) begin
      res = {s, 5'h1F, 10'h000};
    end else if (e < 8'sd1) begin
      res = {s, 15'h0000};
    end else begin
      res = {s, e[4:0], mant};
    end
    return res;
  endfunction

  logic [BITLEN-1:0] stage_a [INPUTS];
  logic [BITLEN-1:0] stage_b [INPUTS];
  logic [BITLEN-1:0] op_a    [INPUTS];
  logic [BITLEN-1:0] op_b    [INPUTS];
  logic [BITLEN-1:0] prod_c  [INPUTS];
  logic [BITLEN-1:0] prod_q  [INPUTS];
  logic              s1, s2;
  logic              stage_we;

  // REST_ADDR parks the bank; any other out-of-range address simply matches
  // no entry in the write loop below.
  assign stage_we = !direct && (AddressSelect != REST_ADDR);

  // Staging bank: lane-0 operand pair written to the addressed entry.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < INPUTS; i++) begin
        stage_a[i] <= '0;
        stage_b[i] <= '0;
      end
    end else begin
      for (int i = 0; i < INPUTS; i++) begin
        if (stage_we && (AddressSelect == ADDRLEN'(i))) begin
          stage_a[i] <= multiplier_input[BITLEN-1:0];
          stage_b[i] <= multiplicand_input[BITLEN-1:0];
        end
      end
    end
  end

  // Start/valid pipeline: a new start always wins and re-times readiness.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      mReady <= '0;
      for (int i = 0; i < INPUTS; i++) begin
        op_a[i] <= '0;
        op_b[i] <= '0;
      end
    end else if (mStart) begin
      s1     <= 1'b1;
      s2     <= 1'b0;
      mReady <= '0;
      for (int i = 0; i < INPUTS; i++) begin
        op_a[i] <= direct ? multiplier_input[i*BITLEN +: BITLEN]   : stage_a[i];
        op_b[i] <= direct ? multiplicand_input[i*BITLEN +: BITLEN] : stage_b[i];
      end
    end else begin
      s1 <= 1'b0;
      s2 <= s1;
      if (s2) mReady <= '1;
    end
  end

  generate
    for (genvar i = 0; i < INPUTS; i++) begin : g_lane
      assign prod_c[i] = fp16_mul(op_a[i], op_b[i]);
    end
  endgenerate

  // Product register: loaded one cycle after the start, held otherwise.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < INPUTS; i++) prod_q[i] <= '0;
    end else if (s1) begin
      for (int i = 0; i < INPUTS; i++) prod_q[i] <= prod_c[i];
    end
  end

  // Result registers: each lane updates only when ready and its Add bit is set.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      flatsumout <= '0;
    end else begin
      for (int i = 0; i < OUTPUTS; i++) begin
        if (mReady[i] && Add[i]) begin
          flatsumout[i*32 +: 32] <= {{(32-BITLEN){1'b0}}, prod_q[i]};
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matrix_accelerator.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_accelerator
// Description : Directed self-checking bench for matrix_accelerator with an
//               expected-result queue. Honors FP_ROUND_NEAREST_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tb_matrix_accelerator;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [47:0] multiplier_input;
  logic [47:0] multiplicand_input;
  logic [3:0]  AddressSelect;
  logic        mStart;
  logic [2:0]  mReady;
  logic        direct;
  logic [2:0]  Add;
  logic [95:0] flatsumout;

  int          n_vec = 0;
  int          n_err = 0;
  logic [95:0] sb_q[$];

  localparam logic [3:0] REST = 4'hF;
`ifdef FP_ROUND_NEAREST_EN
  localparam logic [15:0] L1_EXP = 16'h6F3C;
`else
  localparam logic [15:0] L1_EXP = 16'h6F3B;
`endif

  always #5 Clk = ~Clk;

  matrix_accelerator dut (
    .Clk                (Clk),
    .Rst                (Rst),
    .multiplier_input   (multiplier_input),
    .multiplicand_input (multiplicand_input),
    .AddressSelect      (AddressSelect),
    .mStart             (mStart),
    .mReady             (mReady),
    .direct             (direct),
    .Add                (Add),
    .flatsumout         (flatsumout)
  );

  function automatic logic [95:0] pack3(input logic [15:0] l2, input logic [15:0] l1,
                                        input logic [15:0] l0);
    return {16'h0000, l2, 16'h0000, l1, 16'h0000, l0};
  endfunction

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start one operation, push its expected result, wait for ready and compare.
  task automatic run(input string tag, input logic [47:0] mlt, input logic [47:0] mcd,
                     input logic dir, input logic [2:0] add_m, input logic [95:0] exp);
    int lat;
    multiplier_input   = mlt;
    multiplicand_input = mcd;
    direct             = dir;
    AddressSelect      = REST;
    mStart             = 1'b1;
    Add                = 3'b000;
    sb_q.push_back(exp);
    @(negedge Clk);
    check({tag, "_rdy_clr"}, {93'd0, mReady}, 96'd0);
    mStart = 1'b0;
    Add    = add_m;
    lat    = 0;
    while (mReady !== 3'b111 && lat < 10) begin
      @(negedge Clk);
      lat++;
    end
    check({tag, "_latency"}, 96'(lat), 96'd2);
    @(negedge Clk);
    check({tag, "_out"}, flatsumout, sb_q.pop_front());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst                = 1'b0;
    multiplier_input   = '0;
    multiplicand_input = '0;
    AddressSelect      = REST;
    mStart             = 1'b0;
    direct             = 1'b1;
    Add                = 3'b000;

    #12;
    check("reset_ready", {93'd0, mReady}, 96'd0);
    check("reset_out", flatsumout, 96'd0);
    Rst = 1'b1;
    @(negedge Clk);

    // Direct mode, only lane 1 enabled: lanes 0 and 2 must stay zero.
    run("mask010", {16'h2525, 16'h4958, 16'h5015}, {16'h6DED, 16'h616A, 16'h4F72},
        1'b1, 3'b010, pack3(16'h0000, L1_EXP, 16'h0000));
    // Direct mode, all lanes.
    run("direct", {16'h2525, 16'h4958, 16'h5015}, {16'h6DED, 16'h616A, 16'h4F72},
        1'b1, 3'b111, pack3(16'h579F, L1_EXP, 16'h6399));

    // Staged mode: load bank entries 0..2, then try out-of-range address 3.
    direct = 1'b0;
    Add    = 3'b000;
    AddressSelect = 4'd0; multiplier_input = {32'h0, 16'h3C00}; multiplicand_input = {32'h0, 16'h4000};
    @(negedge Clk);
    AddressSelect = 4'd1; multiplier_input = {32'h0, 16'h4000}; multiplicand_input = {32'h0, 16'h4200};
    @(negedge Clk);
    AddressSelect = 4'd2; multiplier_input = {32'h0, 16'hC000}; multiplicand_input = {32'h0, 16'h3800};
    @(negedge Clk);
    AddressSelect = 4'd3; multiplier_input = {32'h0, 16'h5555}; multiplicand_input = {32'h0, 16'h5555};
    @(negedge Clk);
    run("staged", 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 1'b0, 3'b111,
        pack3(16'hBC00, 16'h4600, 16'h4000));

    // Special operands.
    run("specA", {16'h0400, 16'h7BFF, 16'h7C00}, {16'h0400, 16'h4000, 16'h0000},
        1'b1, 3'b111, pack3(16'h0000, 16'h7C00, 16'h7E00));
    run("specB", {16'h3C00, 16'h7E00, 16'h8000}, {16'h3C00, 16'h3C00, 16'h3C00},
        1'b1, 3'b111, pack3(16'h3C00, 16'h7E00, 16'h8000));

    // Products computed but not written (Add=0): outputs keep specB values.
    run("noadd", {16'h4000, 16'h4000, 16'h4000}, {16'h4000, 16'h4400, 16'h4200},
        1'b1, 3'b000, pack3(16'h3C00, 16'h7E00, 16'h8000));

    // mStart together with Add: the held (old) products are written.
    multiplier_input   = {16'h3C00, 16'h3C00, 16'h3C00};
    multiplicand_input = {16'h3C00, 16'h3C00, 16'h3C00};
    mStart = 1'b1;
    Add    = 3'b111;
    sb_q.push_back(pack3(16'h4400, 16'h4800, 16'h4600));
    @(negedge Clk);
    mStart = 1'b0;
    Add    = 3'b000;
    check("same_cycle_out", flatsumout, sb_q.pop_front());
    check("same_cycle_ready", {93'd0, mReady}, 96'd0);

    // Restart while busy: second start's operands win.
    multiplier_input   = {16'h4000, 16'h4000, 16'h4000};
    multiplicand_input = {16'h4000, 16'h4000, 16'h4000};
    mStart = 1'b1;
    @(negedge Clk);
    run("restart", {16'h4200, 16'h4200, 16'h4200}, {16'h4200, 16'h4000, 16'h3C00},
        1'b1, 3'b111, pack3(16'h4880, 16'h4600, 16'h4200));

    // Asynchronous reset in mid-cycle, no clock edge.
    #2;
    Rst = 1'b0;
    #1;
    check("async_rst_ready", {93'd0, mReady}, 96'd0);
    check("async_rst_out", flatsumout, 96'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
